// File: rtl/water_alarm_manager.sv
// water_alarm_manager
// Consumes the quality code and alert flag from the water quality indicator
// stage once per sample strobe. A fault must repeat PERSIST times before it
// raises the alarm. The alarm stays latched until the operator acknowledges it,
// and it clears only after CLEAR_PERSIST consecutive safe samples. While the
// alarm is unacknowledged the buzzer toggles every BEEP_PERIOD clocks. Each
// cause has a saturating event counter, and proto_err flags any sample whose
// alert flag disagrees with its quality code.
//
// Optional feature (macro WATER_ALARM_TIMESTAMP_EN): adds a free-running 16-bit
// count of valid samples. The alarm_ts output captures that count on every
// alarm entry.
module water_alarm_manager #(
   parameter int PERSIST       = 4,
   parameter int CLEAR_PERSIST = 8,
   parameter int BEEP_PERIOD   = 16,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_valid,
   input  logic [1:0]       quality_in,
   input  logic             alert_in,
   input  logic             ack,
   input  logic             clr_counts,
   output logic             alarm,
   output logic [1:0]       alarm_code,
   output logic             buzzer,
   output logic [1:0]       state_out,
   output logic [CNT_W-1:0] ph_cnt,
   output logic [CNT_W-1:0] turb_cnt,
   output logic [CNT_W-1:0] temp_cnt,
   output logic             proto_err
`ifdef WATER_ALARM_TIMESTAMP_EN
   ,
   output logic [15:0]      alarm_ts
`endif
);

   localparam int BEEP_W = (BEEP_PERIOD > 1) ? $clog2(BEEP_PERIOD) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PENDING = 2'b01,
      ST_ALARM   = 2'b10,
      ST_ACKED   = 2'b11
   } state_t;

   state_t            state_reg;
   logic [1:0]        cand_reg;
   logic [7:0]        pcnt_reg;
   logic [7:0]        ccnt_reg;
   logic [BEEP_W-1:0] beep_reg;
   logic              alarm_reg;
   logic [1:0]        alarm_code_reg;
   logic              buzzer_reg;
   logic              proto_err_reg;
   logic [CNT_W-1:0]  cnt_val [3];

   genvar gi;

   // The sample counts as a fault whenever the quality code is not "safe".
   logic is_fault;
   assign is_fault = (quality_in != 2'b00);

   // This flag selects the post-acknowledge rules. It is set in ACKED, and in
   // ALARM on the cycle an ack arrives, so a sample on that cycle follows the
   // ACKED rules.
   logic ack_path;
   assign ack_path = (state_reg == ST_ACKED) || ((state_reg == ST_ALARM) && ack);

   // On the acknowledge cycle the clear and persistence runs start from zero.
   logic [7:0] ccnt_base;
   logic [7:0] pcnt_base;
   assign ccnt_base = (state_reg == ST_ACKED) ? ccnt_reg : 8'd0;
   assign pcnt_base = (state_reg == ST_ACKED) ? pcnt_reg : 8'd0;

   // Next values of the run counters under the ACKED rules. The legal
   // parameter range keeps these counters from overflowing 8 bits.
   logic [7:0] ack_ccnt_inc;
   logic [7:0] ack_pcnt_next;
   logic       ack_clear;
   assign ack_ccnt_inc  = ccnt_base + 8'd1;
   assign ack_clear     = (ack_ccnt_inc >= 8'(CLEAR_PERSIST));
   assign ack_pcnt_next = ((pcnt_base != 8'd0) && (cand_reg == quality_in))
                          ? (pcnt_base + 8'd1) : 8'd1;

   // Next value of the run counter under the IDLE/PENDING rules. A run
   // continues only in PENDING with the same candidate code.
   logic [7:0] pend_pcnt_next;
   assign pend_pcnt_next = ((state_reg == ST_PENDING) && (cand_reg == quality_in))
                           ? (pcnt_reg + 8'd1) : 8'd1;

   // This flag marks the edge that samples the PERSIST-th qualifying fault. The
   // FSM and the cause counters both use it.
   logic enter_alarm;
   always_comb begin
      enter_alarm = 1'b0;
      if (sample_valid && is_fault) begin
         if (ack_path)
            enter_alarm = (quality_in != alarm_code_reg) && (ack_pcnt_next >= 8'(PERSIST));
         else if (state_reg != ST_ALARM)
            enter_alarm = (pend_pcnt_next >= 8'(PERSIST));
      end
   end

   // Alarm FSM with registered alarm, code and buzzer outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         cand_reg       <= 2'b00;
         pcnt_reg       <= 8'd0;
         ccnt_reg       <= 8'd0;
         beep_reg       <= '0;
         alarm_reg      <= 1'b0;
         alarm_code_reg <= 2'b00;
         buzzer_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_PENDING: begin
               if (sample_valid) begin
                  if (!is_fault) begin
                     state_reg <= ST_IDLE;
                     pcnt_reg  <= 8'd0;
                  end else if (enter_alarm) begin
                     state_reg      <= ST_ALARM;
                     alarm_reg      <= 1'b1;
                     alarm_code_reg <= quality_in;
                     buzzer_reg     <= 1'b1;
                     beep_reg       <= '0;
                     pcnt_reg       <= 8'd0;
                     ccnt_reg       <= 8'd0;
                  end else begin
                     state_reg <= ST_PENDING;
                     cand_reg  <= quality_in;
                     pcnt_reg  <= pend_pcnt_next;
                  end
               end
            end
            default: begin
               if (!ack_path) begin
                  // Unacknowledged alarm: samples are ignored and the buzzer beeps.
                  if (beep_reg == BEEP_W'(BEEP_PERIOD - 1)) begin
                     beep_reg   <= '0;
                     buzzer_reg <= ~buzzer_reg;
                  end else begin
                     beep_reg <= beep_reg + BEEP_W'(1);
                  end
               end else begin
                  if (state_reg == ST_ALARM) begin
                     state_reg  <= ST_ACKED;
                     buzzer_reg <= 1'b0;
                     ccnt_reg   <= 8'd0;
                     pcnt_reg   <= 8'd0;
                  end
                  if (sample_valid) begin
                     if (!is_fault) begin
                        pcnt_reg <= 8'd0;
                        if (ack_clear) begin
                           state_reg <= ST_IDLE;
                           alarm_reg <= 1'b0;
                           ccnt_reg  <= 8'd0;
                        end else begin
                           ccnt_reg <= ack_ccnt_inc;
                        end
                     end else if (quality_in == alarm_code_reg) begin
                        ccnt_reg <= 8'd0;
                        pcnt_reg <= 8'd0;
                     end else if (enter_alarm) begin
                        state_reg      <= ST_ALARM;
                        alarm_reg      <= 1'b1;
                        alarm_code_reg <= quality_in;
                        buzzer_reg     <= 1'b1;
                        beep_reg       <= '0;
                        pcnt_reg       <= 8'd0;
                        ccnt_reg       <= 8'd0;
                     end else begin
                        ccnt_reg <= 8'd0;
                        cand_reg <= quality_in;
                        pcnt_reg <= ack_pcnt_next;
                     end
                  end
               end
            end
         endcase
      end
   end

   // Saturating per-cause alarm event counters. Index 0 counts pH, index 1
   // counts turbidity and index 2 counts temperature. A clear on the same cycle
   // as an increment wins.
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;
         // Count alarm entries whose cause matches this counter.
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               cnt_reg <= '0;
            else if (clr_counts)
               cnt_reg <= '0;
            else if (enter_alarm && (quality_in == 2'(gi + 1)) && (cnt_reg != '1))
               cnt_reg <= cnt_reg + CNT_W'(1);
         end
         assign cnt_val[gi] = cnt_reg;
      end
   endgenerate

   // Sticky flag for a valid sample whose alert flag disagrees with its code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         proto_err_reg <= 1'b0;
      else if (sample_valid && (alert_in != is_fault))
         proto_err_reg <= 1'b1;
   end

`ifdef WATER_ALARM_TIMESTAMP_EN
   logic [15:0] ts_reg;
   logic [15:0] alarm_ts_reg;

   // Free-running count of valid samples, captured on every alarm entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_reg       <= 16'd0;
         alarm_ts_reg <= 16'd0;
      end else begin
         if (sample_valid)
            ts_reg <= ts_reg + 16'd1;
         if (enter_alarm)
            alarm_ts_reg <= ts_reg;
      end
   end

   assign alarm_ts = alarm_ts_reg;
`endif

   assign alarm      = alarm_reg;
   assign alarm_code = alarm_code_reg;
   assign buzzer     = buzzer_reg;
   assign state_out  = state_reg;
   assign ph_cnt     = cnt_val[0];
   assign turb_cnt   = cnt_val[1];
   assign temp_cnt   = cnt_val[2];
   assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_water_alarm_manager.sv
// Testbench for water_alarm_manager.
// The bench applies directed scenarios and then random stimulus. A behavioural
// model reasons about runs of identical faults, runs of safe samples, and time
// spent in the alarm. For each clock edge the bench pushes the expected outputs
// into a queue. A monitor process pops that queue one half-cycle after the edge
// and compares it with the DUT outputs.
module tb_water_alarm_manager;

   localparam int PERSIST       = 4;
   localparam int CLEAR_PERSIST = 8;
   localparam int BEEP_PERIOD   = 16;
   localparam int CNT_W         = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             sample_valid = 1'b0;
   logic [1:0]       quality_in = 2'b00;
   logic             alert_in = 1'b0;
   logic             ack = 1'b0;
   logic             clr_counts = 1'b0;
   logic             alarm;
   logic [1:0]       alarm_code;
   logic             buzzer;
   logic [1:0]       state_out;
   logic [CNT_W-1:0] ph_cnt;
   logic [CNT_W-1:0] turb_cnt;
   logic [CNT_W-1:0] temp_cnt;
   logic             proto_err;
`ifdef WATER_ALARM_TIMESTAMP_EN
   logic [15:0]      alarm_ts;
`endif

   always #5 clk = ~clk;

   water_alarm_manager #(
      .PERSIST(PERSIST), .CLEAR_PERSIST(CLEAR_PERSIST),
      .BEEP_PERIOD(BEEP_PERIOD), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid),
      .quality_in(quality_in), .alert_in(alert_in), .ack(ack),
      .clr_counts(clr_counts), .alarm(alarm), .alarm_code(alarm_code),
      .buzzer(buzzer), .state_out(state_out), .ph_cnt(ph_cnt),
      .turb_cnt(turb_cnt), .temp_cnt(temp_cnt), .proto_err(proto_err)
`ifdef WATER_ALARM_TIMESTAMP_EN
      , .alarm_ts(alarm_ts)
`endif
   );

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   typedef struct {
      int alarm;
      int code;
      int buzzer;
      int state;
      int ph;
      int turb;
      int temp;
      int proto;
   } exp_t;

   exp_t exp_q[$];

   // Reference model. Modes: 0 quiet, 1 fault run in progress, 2 sounding
   // alarm, 3 acknowledged alarm.
   int m_mode, m_code, m_age, m_run_code, m_run_len, m_safe_run, m_proto;
   int m_cnt[3];

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_code = 0; m_age = 0; m_run_code = 0; m_run_len = 0;
      m_safe_run = 0; m_proto = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
   endtask

   task automatic model_step(input bit sv, input int q, input bit al, input bit ak, input bit cl);
      bit entered;
      entered = 1'b0;
      if (m_mode == 2) begin
         if (ak) begin
            m_mode = 3; m_safe_run = 0; m_run_len = 0;
         end else begin
            m_age++;
         end
      end
      if (sv) begin
         if (int'(al) != ((q != 0) ? 1 : 0)) m_proto = 1;
         if (m_mode == 0 || m_mode == 1) begin
            if (q == 0) begin
               m_mode = 0; m_run_len = 0;
            end else begin
               if (m_mode == 1 && q == m_run_code) m_run_len++;
               else begin m_run_code = q; m_run_len = 1; end
               if (m_run_len >= PERSIST) entered = 1'b1;
               else m_mode = 1;
            end
         end else if (m_mode == 3) begin
            if (q == 0) begin
               m_run_len = 0;
               m_safe_run++;
               if (m_safe_run >= CLEAR_PERSIST) m_mode = 0;
            end else if (q == m_code) begin
               m_safe_run = 0; m_run_len = 0;
            end else begin
               m_safe_run = 0;
               if (m_run_len > 0 && q == m_run_code) m_run_len++;
               else begin m_run_code = q; m_run_len = 1; end
               if (m_run_len >= PERSIST) entered = 1'b1;
            end
         end
      end
      if (entered) begin
         m_mode = 2; m_code = q; m_age = 0; m_run_len = 0;
         if (m_cnt[q-1] < (1 << CNT_W) - 1) m_cnt[q-1]++;
      end
      if (cl) for (int i = 0; i < 3; i++) m_cnt[i] = 0;
   endtask

   function automatic void push_exp();
      exp_t e;
      e.alarm  = (m_mode >= 2) ? 1 : 0;
      e.code   = m_code;
      e.buzzer = (m_mode == 2 && ((m_age / BEEP_PERIOD) % 2) == 0) ? 1 : 0;
      e.state  = m_mode;
      e.ph     = m_cnt[0];
      e.turb   = m_cnt[1];
      e.temp   = m_cnt[2];
      e.proto  = m_proto;
      exp_q.push_back(e);
   endfunction

   // Monitor: compare each edge's expected outputs half a cycle after the edge.
   always @(negedge clk) begin
      if (!reset && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         txn++;
         check("state", int'(state_out), e.state);
         check("alarm", int'(alarm), e.alarm);
         check("alarm_code", int'(alarm_code), e.code);
         check("buzzer", int'(buzzer), e.buzzer);
         check("ph_cnt", int'(ph_cnt), e.ph);
         check("turb_cnt", int'(turb_cnt), e.turb);
         check("temp_cnt", int'(temp_cnt), e.temp);
         check("proto_err", int'(proto_err), e.proto);
         $display("txn %0d: state=%0d alarm=%0d code=%0d buzzer=%0d ph=%0d turb=%0d temp=%0d proto=%0d",
                  txn, state_out, alarm, alarm_code, buzzer, ph_cnt, turb_cnt, temp_cnt, proto_err);
      end
   end

   task automatic step(input bit sv, input int q, input bit al, input bit ak, input bit cl);
      @(negedge clk);
      #1;
      sample_valid = sv;
      quality_in   = 2'(q);
      alert_in     = al;
      ack          = ak;
      clr_counts   = cl;
      model_step(sv, q, al, ak, cl);
      push_exp();
   endtask

   task automatic good(input int q);
      step(1'b1, q, (q != 0), 1'b0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " alarm"}, int'(alarm), 0);
      check({tag, " alarm_code"}, int'(alarm_code), 0);
      check({tag, " buzzer"}, int'(buzzer), 0);
      check({tag, " state"}, int'(state_out), 0);
      check({tag, " ph_cnt"}, int'(ph_cnt), 0);
      check({tag, " turb_cnt"}, int'(turb_cnt), 0);
      check({tag, " temp_cnt"}, int'(temp_cnt), 0);
      check({tag, " proto_err"}, int'(proto_err), 0);
   endtask

   // Assert reset between clock edges and check that the outputs clear at once.
   task automatic async_reset_check();
      @(negedge clk);
      #1;
      sample_valid = 0; quality_in = 0; alert_in = 0; ack = 0; clr_counts = 0;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      model_reset();
      #1;
      reset = 1'b0;
      model_step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      push_exp();
   endtask

   initial begin
      int q_last;
      bit sv, al, ak, cl;
      int q;

      model_reset();
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_all_zero("reset");
      model_step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      push_exp();

      // Turbidity run broken by a safe sample raises no alarm.
      good(2); good(2); good(2); good(0); good(2); good(0);

      // pH alarm, then let the buzzer run through a few half-periods.
      for (int i = 0; i < 4; i++) good(1);
      repeat (40) step(1'b0, 0, 1'b0, 1'b0, 1'b0);

      // Ack together with a safe sample, then seven more safe samples clear it.
      step(1'b1, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) good(0);
      repeat (2) step(1'b0, 0, 1'b0, 1'b0, 1'b0);

      // While acked on pH, a temperature run re-enters the alarm.
      for (int i = 0; i < 4; i++) good(1);
      step(1'b0, 0, 1'b0, 1'b1, 1'b0);
      good(1); good(3); good(3); good(3); good(3);
      repeat (3) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < CLEAR_PERSIST; i++) good(0);

      // Drive the pH counter into saturation. The last entry coincides with clr_counts.
      for (int n = 0; n < 257; n++) begin
         for (int i = 0; i < 3; i++) good(1);
         step(1'b1, 1, 1'b1, 1'b0, (n == 256));
         step(1'b0, 0, 1'b0, 1'b1, 1'b0);
         for (int i = 0; i < CLEAR_PERSIST; i++) good(0);
      end

      // A safe sample that carries an alert sets the sticky protocol error.
      step(1'b1, 0, 1'b1, 1'b0, 1'b0);
      good(0); good(2); good(0);

      // Random traffic with a bias toward repeated codes.
      q_last = 0;
      for (int i = 0; i < 2000; i++) begin
         sv = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 9) < 6) q = q_last;
         else q = int'($urandom_range(0, 3));
         q_last = q;
         al = (q != 0);
         if ($urandom_range(0, 59) == 0) al = ~al;
         ak = ($urandom_range(0, 9) == 0);
         cl = ($urandom_range(0, 79) == 0);
         step(sv, q, al, ak, cl);
      end

      // Reset clears the sticky error. Then reset again in the middle of an alarm.
      async_reset_check();
      for (int i = 0; i < 4; i++) good(1);
      repeat (5) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      async_reset_check();
      good(0); good(0);

      // Bounded drain of outstanding expectations.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/water_alarm_manager.md
Name: water_alarm_manager

Overview:
- Downstream of the water quality indicator stage. Consumes its 2-bit quality code and alert flag once per sample strobe.
- Debounces faults: a fault must persist before it raises an alarm.
- Latches the alarm until an operator acknowledges it, then clears only after a run of safe samples.
- Drives a pulsed buzzer and keeps saturating per-cause fault counters for the status display.

Parameters:
- PERSIST, 4: consecutive identical fault samples needed to raise an alarm (legal 1..255).
- CLEAR_PERSIST, 8: consecutive safe samples needed in ACKED to clear the alarm (legal 1..255).
- BEEP_PERIOD, 16: clk cycles per buzzer half-period (legal >=1).
- CNT_W, 8: width of the fault event counters.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_valid  in  1  qualifies quality_in/alert_in for one cycle.
- quality_in  in  2  00 safe, 01 pH, 10 turbidity, 11 temperature.
- alert_in  in  1  upstream alert flag.
- ack  in  1  operator acknowledge, single-cycle pulse.
- clr_counts  in  1  synchronous clear of the three fault counters.
- alarm  out  1  alarm active (ALARM or ACKED).
- alarm_code  out  2  cause of the current or last alarm.
- buzzer  out  1  audible drive.
- state_out  out  2  00 IDLE, 01 PENDING, 10 ALARM, 11 ACKED.
- ph_cnt, turb_cnt, temp_cnt  out  CNT_W  alarm events per cause.
- proto_err  out  1  sticky consistency error.

Behaviour:
- Reset: all outputs 0, state IDLE, internal persistence, clear and beep counters 0.
- Fault definition:
  - A sample is a fault iff quality_in != 00.
  - alert_in does not affect state.
  - If alert_in != (quality_in != 00) on a valid sample, proto_err sets and stays 1 until reset.
- State transitions evaluate only when sample_valid=1, except ack and the beep timer.
- IDLE:
  - Fault sample: cand <= quality_in, pcnt <= 1, go to PENDING.
  - If PERSIST=1, go directly to ALARM.
- PENDING:
  - Same code: pcnt+1. On reaching PERSIST, go to ALARM.
  - Different fault code: cand <= new code, pcnt <= 1.
  - Safe sample: back to IDLE, pcnt <= 0.
- ALARM entry (the edge that samples the PERSIST-th fault):
  - Same edge: alarm <= 1, alarm_code <= cand, buzzer <= 1, beep counter <= 0.
  - The matching cause counter increments, saturating at all-ones.
  - Alarm is visible one cycle after the qualifying sample cycle.
- ALARM:
  - Latched; samples are ignored.
  - buzzer toggles every BEEP_PERIOD cycles.
  - ack=1: go to ACKED, buzzer <= 0, ccnt <= 0.
  - If sample_valid is also 1 that cycle, the sample is applied under ACKED rules.
- ACKED:
  - alarm=1, buzzer=0.
  - Safe sample: ccnt+1. On reaching CLEAR_PERSIST, go to IDLE with alarm <= 0; alarm_code holds its value.
  - Fault equal to alarm_code: ccnt <= 0.
  - Fault with a different code: ccnt <= 0 and new-cause persistence tracked as in PENDING. On reaching PERSIST, re-enter ALARM with the new code and increment its counter.
- ack outside ALARM is ignored.
- clr_counts zeroes the three counters. If clr_counts coincides with an increment, clear wins.
- Counters saturate and never wrap. Internal pcnt and ccnt are 8 bits and cannot overflow given the legal parameter ranges.
- Asynchronous reset mid-alarm returns everything to reset values immediately.

Optional Feature:
- Macro: WATER_ALARM_TIMESTAMP_EN.
- When defined:
  - A 16-bit free-running valid-sample counter `ts` is added; it wraps and resets to 0.
  - New output alarm_ts[15:0] latches `ts` on every ALARM entry and holds otherwise; reset value 0.
- When undefined: no counter and no port. All other behaviour is identical.

Test Plan:
- Reset, then 4 valid samples of 01 with alert_in=1 -> state PENDING for samples 1-3. Cycle after sample 4: alarm=1, alarm_code=01, ph_cnt=1, buzzer=1, toggling every 16 cycles.
- Samples 10,10,10,00,10 -> no alarm; state returns IDLE after the 00 sample; turb_cnt=0.
- In ALARM, pulse ack together with a safe sample -> ACKED, buzzer=0, ccnt=1. Then 7 more safe samples -> alarm=0, state IDLE, alarm_code retained.
- In ACKED with alarm_code=01: 4 samples of 11 -> re-ALARM, alarm_code=11, temp_cnt=1, buzzer restarts at 1.
- Force 255 pH alarm events with CNT_W=8 -> ph_cnt stays 255. Assert clr_counts together with the next increment -> 0.
- Sample quality_in=00 with alert_in=1 -> proto_err=1, held through later good samples, cleared only by reset. Reset asserted mid-ALARM -> all outputs 0 immediately.
